// File: rtl/wb_master_pkg.sv
// Shared types and defaults for the Wishbone command master.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_TO_CYCLES = 256;
    localparam int DEF_TO_W      = 9;
    localparam int ERR_CNT_W     = 16;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: a down-counter loaded on clear, decremented while enabled.
// expire is high during the TO_CYCLES-th enabled cycle after a clear.
// TO_CYCLES = 0 disables expiry.
module wb_timeout_cnt #(
    parameter int TO_CYCLES = 256,
    parameter int TO_W      = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // Loading TO_CYCLES-1 makes the zero compare hit on the TO_CYCLES-th enabled edge.
    localparam logic [TO_W-1:0] LOAD_VAL = TO_W'((TO_CYCLES > 0) ? (TO_CYCLES - 1) : 0);
    localparam logic            TO_EN    = (TO_CYCLES != 0);

    logic [TO_W-1:0] cnt;

    // Remaining-cycle counter; it holds at zero so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD_VAL;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = TO_EN && enable && (cnt == '0);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: one command in, one single WB transfer, one response out.
//
//  state | meaning
//  IDLE  | cmd_ready=1, waiting for a command
//  BUS   | cyc/stb asserted, waiting for ack or timeout
//  RESP  | response presented, waiting for rsp_ready
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TO_CYCLES = DEF_TO_CYCLES,
    parameter int TO_W      = DEF_TO_W
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDR_W-1:0]    cmd_adr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    input  logic [DATA_W/8-1:0]  cmd_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic                 wbm_cyc,
    output logic                 wbm_stb,
    output logic                 wbm_we,
    output logic [ADDR_W-1:0]    wbm_adr,
    output logic [DATA_W-1:0]    wbm_wdata,
    output logic [DATA_W/8-1:0]  wbm_sel,
    input  logic                 wbm_ack,
    input  logic [DATA_W-1:0]    wbm_rdata,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t state;
    logic   accept;
    logic   to_expire;

    // cmd_ready is a register that is high exactly in IDLE, so accept needs no extra gating.
    assign accept = cmd_ready && cmd_valid;

    wb_timeout_cnt #(
        .TO_CYCLES (TO_CYCLES),
        .TO_W      (TO_W)
    ) u_timeout (
        .clk    (wb_clk),
        .rst_n  (wb_rst_n),
        .clear  (accept),
        .enable (state == BUS),
        .expire (to_expire)
    );

    // Sequencer with registered bus, response and error-count outputs.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc   <= 1'b0;
            wbm_stb   <= 1'b0;
            wbm_we    <= 1'b0;
            wbm_adr   <= '0;
            wbm_wdata <= '0;
            wbm_sel   <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= BUS;
                        cmd_ready <= 1'b0;
                        wbm_cyc   <= 1'b1;
                        wbm_stb   <= 1'b1;
                        wbm_we    <= cmd_we;
                        wbm_adr   <= cmd_adr;
                        wbm_wdata <= cmd_wdata;
                        wbm_sel   <= cmd_sel;
                    end
                end
                BUS: begin
                    // Ack takes priority over a timeout expiring on the same edge.
                    if (wbm_ack) begin
                        state     <= RESP;
                        wbm_cyc   <= 1'b0;
                        wbm_stb   <= 1'b0;
                        wbm_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wbm_we ? '0 : wbm_rdata;
                    end else if (to_expire) begin
                        state     <= RESP;
                        wbm_cyc   <= 1'b0;
                        wbm_stb   <= 1'b0;
                        wbm_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    wbm_cyc   <= 1'b0;
                    wbm_stb   <= 1'b0;
                    wbm_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a response scoreboard.
module tb_wb_cmd_master;

    localparam int TO = 8;

    logic        wb_clk;
    logic        wb_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_wdata;
    logic [3:0]  wbm_sel;
    logic        wbm_ack;
    logic [31:0] wbm_rdata;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_rdata[$];
    logic        sb_err[$];

    wb_cmd_master #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .TO_CYCLES (TO),
        .TO_W      (4)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_wdata (cmd_wdata),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wbm_cyc   (wbm_cyc),
        .wbm_stb   (wbm_stb),
        .wbm_we    (wbm_we),
        .wbm_adr   (wbm_adr),
        .wbm_wdata (wbm_wdata),
        .wbm_sel   (wbm_sel),
        .wbm_ack   (wbm_ack),
        .wbm_rdata (wbm_rdata),
        .err_cnt   (err_cnt)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Step to just after the next rising edge; inputs change and outputs are checked here.
    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every rsp handshake.
    always @(negedge wb_clk) begin
        if (wb_rst_n && rsp_valid && rsp_ready) begin
            if (sb_rdata.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rsp_rdata", rsp_rdata, sb_rdata.pop_front());
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb_err.pop_front()});
            end
        end
    end

    // Issue one command and play the slave: ack in stb-high cycle ack_wait+1 (ack_wait<0: never).
    task automatic do_cmd(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [3:0] sel, input int ack_wait,
                          input logic [31:0] rd, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_stb);
        int n;
        sb_rdata.push_back(exp_rd);
        sb_err.push_back(exp_err);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_wdata = wd;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
        cmd_adr   = 32'h0BAD_0BAD;
        cmd_wdata = 32'h0BAD_0BAD;
        n = 0;
        while (wbm_stb && n < 50) begin
            n++;
            chk({tag, "_bus_ctrl"}, {25'd0, wbm_cyc, wbm_stb, wbm_we, wbm_sel},
                {25'd0, 1'b1, 1'b1, we, sel});
            chk({tag, "_bus_adr"}, wbm_adr, adr);
            chk({tag, "_bus_wdata"}, wbm_wdata, wd);
            wbm_ack   = (n == ack_wait + 1);
            wbm_rdata = wbm_ack ? rd : 32'hDEAD_BEEF;
            tick();
        end
        wbm_ack   = 1'b0;
        wbm_rdata = 32'h0;
        chk({tag, "_stb_cycles"}, n, exp_stb);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_post_ctrl"}, {29'd0, wbm_cyc, wbm_stb, wbm_we}, 32'd0);
        chk({tag, "_adr_kept"}, wbm_adr, adr);
        if (rsp_ready) begin
            tick();
            chk({tag, "_back_idle"}, {30'd0, cmd_ready, rsp_valid}, 32'd2);
        end
    endtask

    initial begin
        wb_rst_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_wdata = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b1;
        wbm_ack   = 1'b0;
        wbm_rdata = '0;
        repeat (3) tick();
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_outputs", {28'd0, wbm_cyc, wbm_stb, wbm_we, rsp_valid}, 32'd0);
        chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
        wb_rst_n = 1'b1;
        repeat (2) tick();

        // 1: write, immediate ack; rdata must read 0 even though the slave drives data
        do_cmd("t1", 1'b1, 32'h3000_0000, 32'hA5A5_5A5A, 4'hF, 0, 32'hFFFF_0000,
               32'h0, 1'b0, 1);
        // 2: read, 5 wait states
        do_cmd("t2", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 5, 32'h1234_5678,
               32'h1234_5678, 1'b0, 6);
        // 3: read, slave never acks
        do_cmd("t3", 1'b0, 32'h3000_0008, 32'h0, 4'h3, -1, 32'h0, 32'h0, 1'b1, TO);
        chk("t3_err_cnt", {16'd0, err_cnt}, 32'd1);
        // 4: ack on the same edge the timeout expires
        do_cmd("t4", 1'b0, 32'h3000_000C, 32'h0, 4'hF, TO - 1, 32'h5555_AAAA,
               32'h5555_AAAA, 1'b0, TO);
        chk("t4_err_cnt", {16'd0, err_cnt}, 32'd1);
        // write timeout bumps the counter again
        do_cmd("t4b", 1'b1, 32'h3000_0010, 32'h7777_8888, 4'hC, -1, 32'h0, 32'h0, 1'b1, TO);
        chk("t4b_err_cnt", {16'd0, err_cnt}, 32'd2);

        // ack while idle is ignored
        wbm_ack   = 1'b1;
        wbm_rdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_ack", {29'd0, wbm_cyc, rsp_valid, cmd_ready}, 32'd1);
        end
        wbm_ack = 1'b0;

        // 5: response back-pressure
        rsp_ready = 1'b0;
        do_cmd("t5", 1'b0, 32'h3000_0020, 32'h0, 4'hF, 2, 32'hCAFE_F00D,
               32'hCAFE_F00D, 1'b0, 3);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0024;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_rdata", rsp_rdata, 32'hCAFE_F00D);
            chk("t5_hold_flags", {28'd0, rsp_valid, rsp_err, cmd_ready, wbm_cyc}, 32'h8);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("t5_release", {29'd0, cmd_ready, rsp_valid, wbm_cyc}, 32'h4);
        tick();
        chk("t5_no_accept", {31'd0, wbm_cyc}, 32'd0);

        // 6: reset during a wait state
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0030;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t6_in_bus", {30'd0, wbm_cyc, wbm_stb}, 32'd3);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("t6_async_drop", {30'd0, wbm_cyc, wbm_stb}, 32'd0);
        tick();
        wb_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_after", {29'd0, cmd_ready, rsp_valid, wbm_cyc}, 32'h4);
        end
        chk("t6_err_cnt", {16'd0, err_cnt}, 32'd0);

        tick();
        chk("sb_empty", sb_rdata.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
